// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the register-file writeback path.
//   XLEN_DEFAULT  : default writeback data width
//   REG_ADDR_W    : register address width (32 architectural registers)
//   STARVE_CTR_W  : width of the load/store starvation counter
//   wb_pri_e      : writeback arbiter priority state
//   wb_req_t      : one writeback request at the default data width
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int STARVE_CTR_W = 4;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } wb_pri_e;

  typedef struct packed {
    logic                    valid;
    logic [REG_ADDR_W-1:0]   rd_addr;
    logic [XLEN_DEFAULT-1:0] rd_data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_starve_ctr.sv
// -----------------------------------------------------------------------------
// regfile_wb_starve_ctr
// Counts consecutive cycles the load/store source is valid but refused and
// raises a force request when the count reaches STARVE_LIMIT.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_b_valid    : source B has a write pending
//   i_b_ready    : source B is being accepted this cycle
//   o_force_req  : the count reaches STARVE_LIMIT at the coming edge
// -----------------------------------------------------------------------------
module regfile_wb_starve_ctr
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_b_valid,
  input  logic i_b_ready,
  output logic o_force_req
);

  localparam logic [STARVE_CTR_W-1:0] LIMIT = STARVE_CTR_W'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  logic [STARVE_CTR_W-1:0] cnt_p0;
  logic [STARVE_CTR_W-1:0] cnt_nxt;

  // A refused cycle advances the count (saturating); an accepted B write or
  // an idle B both clear it.
  always_comb begin
    cnt_nxt = '0;
    if (i_b_valid && !i_b_ready) begin
      cnt_nxt = (cnt_p0 == LIMIT) ? cnt_p0 : cnt_p0 + 1'b1;
    end
  end

  // Looking at the next value lets B take over on the cycle right after its
  // STARVE_LIMIT-th refusal rather than one cycle later.
  assign o_force_req = (cnt_nxt == LIMIT);

  // ---- stage p0: counter register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU/execute path
// (source A, default priority) and the load/store unit (source B). A
// starvation counter hands priority to B after STARVE_LIMIT refused cycles.
// The winning write is registered and appears on o_rd_addr/o_rd_data one
// cycle after the handshake; o_rd_addr = 0 means no write.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_a_valid/o_a_ready/i_a_rd_*   : source A writeback handshake
//   i_b_valid/o_b_ready/i_b_rd_*   : source B writeback handshake
//   o_rd_addr, o_rd_data           : register file write port
//   o_b_forced                     : arbiter currently prioritises B
// Optional (macro REGFILE_WB_BYPASS_EN):
//   i_rs1_addr, i_rs2_addr         : read addresses of the register file
//   o_rsN_fwd_valid, o_rsN_fwd_data: forward the staged write to a read of
//                                    the same register in the same cycle
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = XLEN_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_valid,
  output logic                  o_a_ready,
  input  logic [REG_ADDR_W-1:0] i_a_rd_addr,
  input  logic [XLEN-1:0]       i_a_rd_data,
  input  logic                  i_b_valid,
  output logic                  o_b_ready,
  input  logic [REG_ADDR_W-1:0] i_b_rd_addr,
  input  logic [XLEN-1:0]       i_b_rd_data,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data,
  output logic                  o_b_forced
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_fwd_valid,
  output logic [XLEN-1:0]       o_rs1_fwd_data,
  output logic                  o_rs2_fwd_valid,
  output logic [XLEN-1:0]       o_rs2_fwd_data
`endif
);

  // Request record at the configured width (the package record is fixed
  // at the default width).
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_data;
  } wb_req_w_t;

  wb_pri_e               state_p0;
  logic                  a_xfer;
  logic                  b_xfer;
  logic                  force_req;
  wb_req_w_t             win_p0;
  logic [REG_ADDR_W-1:0] rd_addr_p1;
  logic [XLEN-1:0]       rd_data_p1;

  // Readiness depends only on the state and the other source's valid, so
  // each ready is independent of its own valid.
  assign o_a_ready = !(state_p0 == PRI_B && i_b_valid);
  assign o_b_ready = (state_p0 == PRI_B) || !i_a_valid;
  assign a_xfer    = i_a_valid && o_a_ready;
  assign b_xfer    = i_b_valid && o_b_ready;

  regfile_wb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_b_valid   (i_b_valid),
    .i_b_ready   (o_b_ready),
    .o_force_req (force_req)
  );

  // The ready equations make a_xfer and b_xfer mutually exclusive.
  always_comb begin
    win_p0 = '0;
    if (a_xfer) begin
      win_p0 = '{valid: 1'b1, rd_addr: i_a_rd_addr, rd_data: i_a_rd_data};
    end else if (b_xfer) begin
      win_p0 = '{valid: 1'b1, rd_addr: i_b_rd_addr, rd_data: i_b_rd_data};
    end
  end

  // ---- stage p0: priority state ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_p0 <= PRI_A;
    end else begin
      case (state_p0)
        PRI_A:   if (force_req) state_p0 <= PRI_B;
        PRI_B:   if (b_xfer || !i_b_valid) state_p0 <= PRI_A;
        default: state_p0 <= PRI_A;
      endcase
    end
  end

  assign o_b_forced = (state_p0 == PRI_B);

  // ---- stage p1: staged register-file write ----
  // Writes to x0 are accepted but turned into an idle cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_addr_p1 <= '0;
      rd_data_p1 <= '0;
    end else if (win_p0.valid && win_p0.rd_addr != '0) begin
      rd_addr_p1 <= win_p0.rd_addr;
      rd_data_p1 <= win_p0.rd_data;
    end else begin
      rd_addr_p1 <= '0;
      rd_data_p1 <= '0;
    end
  end

  assign o_rd_addr = rd_addr_p1;
  assign o_rd_data = rd_data_p1;

`ifdef REGFILE_WB_BYPASS_EN
  // Covers a read of the register being written in the same cycle.
  assign o_rs1_fwd_valid = (rd_addr_p1 != '0) && (rd_addr_p1 == i_rs1_addr);
  assign o_rs1_fwd_data  = rd_data_p1;
  assign o_rs2_fwd_valid = (rd_addr_p1 != '0) && (rd_addr_p1 == i_rs2_addr);
  assign o_rs2_fwd_data  = rd_data_p1;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter (STARVE_LIMIT = 4, XLEN = 32).
// Directed vectors, a mid-operation asynchronous reset, and randomized
// traffic checked against a cycle-level behavioural model.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ar;
    logic        br;
    logic        bf;
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_a_valid;
  logic        o_a_ready;
  logic [4:0]  i_a_rd_addr;
  logic [31:0] i_a_rd_data;
  logic        i_b_valid;
  logic        o_b_ready;
  logic [4:0]  i_b_rd_addr;
  logic [31:0] i_b_rd_data;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_b_forced;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  i_rs1_addr = '0;
  logic [4:0]  i_rs2_addr = '0;
  logic        o_rs1_fwd_valid;
  logic [31:0] o_rs1_fwd_data;
  logic        o_rs2_fwd_valid;
  logic [31:0] o_rs2_fwd_data;
`endif

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit m_forced = 1'b0;
  int m_streak = 0;

  // pending source requests for handshake-compliant random traffic
  bit          a_pend = 1'b0;
  bit          b_pend = 1'b0;
  logic [4:0]  a_addr_q, b_addr_q;
  logic [31:0] a_data_q, b_data_q;

  vec_t tab[11];

  regfile_wb_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .XLEN         (32)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_a_valid   (i_a_valid),
    .o_a_ready   (o_a_ready),
    .i_a_rd_addr (i_a_rd_addr),
    .i_a_rd_data (i_a_rd_data),
    .i_b_valid   (i_b_valid),
    .o_b_ready   (o_b_ready),
    .i_b_rd_addr (i_b_rd_addr),
    .i_b_rd_data (i_b_rd_data),
    .o_rd_addr   (o_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_b_forced  (o_b_forced)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .i_rs1_addr      (i_rs1_addr),
    .i_rs2_addr      (i_rs2_addr),
    .o_rs1_fwd_valid (o_rs1_fwd_valid),
    .o_rs1_fwd_data  (o_rs1_fwd_data),
    .o_rs2_fwd_valid (o_rs2_fwd_valid),
    .o_rs2_fwd_data  (o_rs2_fwd_data)
`endif
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: A has priority unless B was refused LIMIT cycles in a row, in
  // which case B owns the next cycle. Winner appears one cycle later;
  // x0 or no winner gives an idle (0/0) output.
  task automatic model(input vec_t vi, output vec_t vo);
    logic ax, bx;
    vo    = vi;
    vo.ar = !(m_forced && vi.bv);
    vo.br = m_forced || !vi.av;
    vo.bf = m_forced;
    ax    = vi.av && vo.ar;
    bx    = vi.bv && vo.br;
    vo.ea = '0;
    vo.ed = '0;
    if (ax && vi.aa != 0) begin
      vo.ea = vi.aa; vo.ed = vi.ad;
    end else if (bx && vi.ba != 0) begin
      vo.ea = vi.ba; vo.ed = vi.bd;
    end
    if (vi.bv && !vo.br) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
    else                 m_streak = 0;
    m_forced = !m_forced && (m_streak == LIMIT);
  endtask

  // Drive one cycle starting just after an active edge; check readies in
  // that cycle and the registered output just after the next edge.
  task automatic apply(input vec_t v, input string tag);
    i_a_valid   = v.av;
    i_a_rd_addr = v.aa;
    i_a_rd_data = v.ad;
    i_b_valid   = v.bv;
    i_b_rd_addr = v.ba;
    i_b_rd_data = v.bd;
    #1;
    chk({tag, ".a_ready"}, 32'(o_a_ready), 32'(v.ar));
    chk({tag, ".b_ready"}, 32'(o_b_ready), 32'(v.br));
    chk({tag, ".b_forced"}, 32'(o_b_forced), 32'(v.bf));
    @(posedge i_clk);
    #1;
    chk({tag, ".rd_addr"}, 32'(o_rd_addr), 32'(v.ea));
    chk({tag, ".rd_data"}, o_rd_data, v.ed);
`ifdef REGFILE_WB_BYPASS_EN
    i_rs1_addr = v.ea;
    i_rs2_addr = 5'($urandom_range(31));
    #1;
    chk({tag, ".rs1_fwd_valid"}, 32'(o_rs1_fwd_valid), 32'(v.ea != 0));
    chk({tag, ".rs1_fwd_data"}, o_rs1_fwd_data, v.ed);
    chk({tag, ".rs2_fwd_valid"}, 32'(o_rs2_fwd_valid),
        32'(v.ea != 0 && i_rs2_addr == v.ea));
`endif
  endtask

  task automatic traffic(input int n, input int pa, input int pb, input string tag);
    vec_t v, e;
    for (int i = 0; i < n; i++) begin
      if (!a_pend && $urandom_range(99) < pa) begin
        a_pend = 1'b1;
        a_addr_q = 5'($urandom_range(31));
        a_data_q = $urandom;
      end
      if (!b_pend && $urandom_range(99) < pb) begin
        b_pend = 1'b1;
        b_addr_q = 5'($urandom_range(31));
        b_data_q = $urandom;
      end
      v.av = a_pend;
      v.aa = a_pend ? a_addr_q : 5'($urandom_range(31));
      v.ad = a_pend ? a_data_q : $urandom;
      v.bv = b_pend;
      v.ba = b_pend ? b_addr_q : 5'($urandom_range(31));
      v.bd = b_pend ? b_data_q : $urandom;
      v.ar = 1'b0; v.br = 1'b0; v.bf = 1'b0; v.ea = '0; v.ed = '0;
      model(v, e);
      apply(e, tag);
      if (e.av && e.ar) a_pend = 1'b0;
      if (e.bv && e.br) b_pend = 1'b0;
    end
  endtask

  initial begin
    vec_t e;
    vec_t v;
    //         av   aa     ad            bv   ba     bd            ar   br   bf   ea     ed
    tab[0]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd7, 32'h1234,     1'b1, 1'b0, 1'b0, 5'd1, 32'h11};
    tab[1]  = '{1'b1, 5'd2, 32'h22,       1'b1, 5'd7, 32'h1234,     1'b1, 1'b0, 1'b0, 5'd2, 32'h22};
    tab[2]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd7, 32'h1234,     1'b1, 1'b0, 1'b0, 5'd3, 32'h33};
    tab[3]  = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd7, 32'h1234,     1'b1, 1'b0, 1'b0, 5'd4, 32'h44};
    tab[4]  = '{1'b1, 5'd5, 32'h55,       1'b1, 5'd7, 32'h1234,     1'b0, 1'b1, 1'b1, 5'd7, 32'h1234};
    tab[5]  = '{1'b1, 5'd5, 32'h55,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd5, 32'h55};
    tab[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
    tab[7]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    tab[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
    tab[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
    tab[10] = '{1'b1, 5'd0, 32'hABCD,     1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 32'h0};

    // Reset held with both sources valid
    i_rst_n     = 1'b0;
    i_a_valid   = 1'b1;
    i_a_rd_addr = 5'd3;
    i_a_rd_data = 32'hCAFE;
    i_b_valid   = 1'b1;
    i_b_rd_addr = 5'd7;
    i_b_rd_data = 32'h1234;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.rd_addr", 32'(o_rd_addr), 32'd0);
    chk("rst.rd_data", o_rd_data, 32'd0);
    chk("rst.b_forced", 32'(o_b_forced), 32'd0);
    chk("rst.a_ready", 32'(o_a_ready), 32'd1);
    chk("rst.b_ready", 32'(o_b_ready), 32'd0);
    i_rst_n = 1'b1;

    // Directed vectors: contention, A-only, x0 drops
    for (int i = 0; i < 11; i++) begin
      model(tab[i], e);
      apply(tab[i], $sformatf("vec%0d", i));
    end

    // Build up a starvation count of 3 while x9 is being written out
    v = '{1'b1, 5'd1, 32'h101, 1'b1, 5'd7, 32'h777, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    model(v, e); apply(e, "pre_rst0");
    v.aa = 5'd2; v.ad = 32'h202;
    model(v, e); apply(e, "pre_rst1");
    v.aa = 5'd9; v.ad = 32'h909;
    model(v, e); apply(e, "pre_rst2");
    chk("pre_rst.rd_addr9", 32'(o_rd_addr), 32'd9);

    // Asynchronous reset between edges
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst.rd_addr", 32'(o_rd_addr), 32'd0);
    chk("async_rst.rd_data", o_rd_data, 32'd0);
    chk("async_rst.b_forced", 32'(o_b_forced), 32'd0);
    #3 i_rst_n = 1'b1;
    m_forced = 1'b0;
    m_streak = 0;
    a_pend   = 1'b0;
    b_pend   = 1'b0;

    // Full contention after reset: a cleared counter means 4 A wins first
    traffic(7, 100, 100, "post_rst");

    // Randomized traffic at several loads
    traffic(300, 60, 50, "rnd_mid");
    traffic(300, 95, 95, "rnd_heavy");
    traffic(200, 20, 20, "rnd_light");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
